// File: rtl/i2s_pkg.sv
// i2s_pkg: shared framing and channel encodings for the I2S transmitter.
package i2s_pkg;
  typedef enum logic {I2S_MODE_LJ = 1'b0, I2S_MODE_I2S = 1'b1} mode_e;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} ch_e;
endpackage

// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo: stereo frame FIFO, combinational head read, full/empty guarded push/pop.
module i2s_frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;
  assign full  = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign rdata = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/i2s_stereo_tx.sv
// i2s_stereo_tx: buffered stereo serializer, left-justified or I2S framing on sck.
module i2s_stereo_tx
  import i2s_pkg::*;
#(
  parameter int BIT_WIDTH  = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            sck,
  input  logic                            rst,
  input  logic                            mode,
  input  logic [BIT_WIDTH-1:0]            left_sample,
  input  logic [BIT_WIDTH-1:0]            right_sample,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  output logic                            ws,
  output logic                            sd,
  output logic                            underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int CW = $clog2(2*SLOT_WIDTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int FW = 2*SLOT_WIDTH;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] sh_q, sh_d, sh_next, frame;
  logic [SLOT_WIDTH-1:0] l_slot, r_slot;
  logic [2*BIT_WIDTH-1:0] head;
  mode_e mode_q, mode_d;
  ch_e ws_q, ws_d;
  logic sd_q, sd_d, und_q, und_d;
  logic load, last, push, pop, full, empty;
  i2s_frame_fifo #(.WIDTH(2*BIT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sck),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({left_sample, right_sample}),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );
  assign sample_ready = fifo_level != LW'(FIFO_DEPTH);
  assign push = sample_valid && sample_ready;
  assign pop  = load && !empty;
  assign ws = ws_q;
  assign sd = sd_q;
  assign underflow = und_q;
  always_comb begin
    last    = cnt_q == CW'(FW-1);
    load    = cnt_q == ((mode_q == I2S_MODE_I2S) ? CW'(1) : CW'(0));
    l_slot  = SLOT_WIDTH'(head[2*BIT_WIDTH-1:BIT_WIDTH]) << (SLOT_WIDTH-BIT_WIDTH);
    r_slot  = SLOT_WIDTH'(head[BIT_WIDTH-1:0]) << (SLOT_WIDTH-BIT_WIDTH);
    frame   = empty ? '0 : {l_slot, r_slot};
    // the first bit of a freshly loaded frame leaves on the load edge itself
    sh_next = load ? frame : sh_q;
    sd_d    = sh_next[FW-1];
    sh_d    = sh_next << 1;
    ws_d    = (cnt_q >= CW'(SLOT_WIDTH)) ? CH_RIGHT : CH_LEFT;
    und_d   = load && empty;
    cnt_d   = last ? '0 : cnt_q + CW'(1);
    mode_d  = last ? mode_e'(mode) : mode_q;
  end
  always_ff @(posedge sck) begin
    if (rst) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      ws_q   <= CH_LEFT;
      sd_q   <= 1'b0;
      und_q  <= 1'b0;
      mode_q <= mode_e'(mode);
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      ws_q   <= ws_d;
      sd_q   <= sd_d;
      und_q  <= und_d;
      mode_q <= mode_d;
    end
  end
endmodule

// File: tb/tb_i2s_stereo_tx.sv
// tb_i2s_stereo_tx: scoreboard bench, queued frames compared bit by bit as they serialize.
module tb_i2s_stereo_tx;
  logic sck = 0, rst = 1, mode = 0, sample_valid = 0;
  logic [23:0] left_sample = '0, right_sample = '0;
  logic sample_ready, ws, sd, underflow;
  logic [2:0] fifo_level;
  int errors = 0, checks = 0, mon_cnt = -1, nxt = 0;
  logic [47:0] q[$];
  logic [47:0] cur = '0;
  logic tb_mode = 0;
  i2s_stereo_tx dut (
    .sck(sck), .rst(rst), .mode(mode), .left_sample(left_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .ws(ws), .sd(sd),
    .underflow(underflow), .fifo_level(fifo_level)
  );
  always #5 sck = ~sck;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cnt %0d: got %0h expected %0h", tag, mon_cnt, act, exp);
    end
  endtask
  function automatic logic slot_bit(input logic [47:0] f, input int pos);
    logic [23:0] s;
    int k;
    s = (pos >= 32) ? f[23:0] : f[47:24];
    k = pos % 32;
    return (k < 24) ? s[23-k] : 1'b0;
  endfunction
  logic r_s, v_s, rd_s, m_s, eu;
  logic [47:0] d_s;
  int c, pos;
  always @(posedge sck) begin
    r_s = rst; v_s = sample_valid; rd_s = sample_ready; m_s = mode;
    d_s = {left_sample, right_sample};
    #1;
    if (r_s) begin
      q.delete(); cur = '0; tb_mode = m_s; mon_cnt = -1; nxt = 0;
      chk("rst_ws", ws, 0); chk("rst_sd", sd, 0); chk("rst_underflow", underflow, 0);
    end else begin
      c = nxt; eu = 0;
      if (c == (tb_mode ? 1 : 0)) begin
        if (q.size() == 0) begin cur = '0; eu = 1; end
        else cur = q.pop_front();
      end
      if (v_s && rd_s) q.push_back(d_s);
      pos = (c - (tb_mode ? 1 : 0) + 64) % 64;
      mon_cnt = c;
      chk("ws", ws, c >= 32);
      chk("sd", sd, slot_bit(cur, pos));
      chk("underflow", underflow, eu);
      if (c == 63) tb_mode = m_s;
      nxt = (c + 1) % 64;
    end
    chk("level", fifo_level, q.size());
    chk("ready", sample_ready, q.size() != 4);
  end
  task automatic send(input logic [23:0] l, input logic [23:0] r);
    int n = 0;
    left_sample = l; right_sample = r; sample_valid = 1;
    while (!sample_ready && n < 500) begin @(negedge sck); n++; end
    chk("send_ready", sample_ready, 1);
    @(negedge sck);
    sample_valid = 0;
  endtask
  task automatic wait_cnt(input int t);
    int n = 0;
    @(negedge sck);
    while (mon_cnt != t && n < 200) begin @(negedge sck); n++; end
    chk("wait_cnt", 64'(mon_cnt), 64'(t));
  endtask
  initial begin
    repeat (3) @(negedge sck);
    rst = 0;
    repeat (130) @(negedge sck);
    wait_cnt(60);
    send(24'hA5A5A5, 24'h123456);
    repeat (70) @(negedge sck);
    wait_cnt(10);
    mode = 1;
    wait_cnt(60);
    send(24'hA5A5A5, 24'h123456);
    repeat (70) @(negedge sck);
    wait_cnt(0);
    send(24'h5A5A5A, 24'hFEDCBA);
    repeat (70) @(negedge sck);
    wait_cnt(10);
    mode = 0;
    wait_cnt(2);
    for (int i = 0; i < 5; i++) send(24'(i * 24'h111111 + 24'h010203), 24'($urandom));
    chk("full_level", fifo_level, 4);
    repeat (200) @(negedge sck);
    wait_cnt(2);
    send(24'hC0FFEE, 24'hBADA55);
    send(24'h800001, 24'h7FFFFE);
    wait_cnt(10);
    mode = 1;
    repeat (100) @(negedge sck);
    wait_cnt(2);
    send(24'h13579B, 24'h2468AC);
    send(24'hFFFFFF, 24'h000001);
    wait_cnt(40);
    chk("pre_rst_level", fifo_level, 2);
    rst = 1;
    @(negedge sck);
    rst = 0;
    repeat (140) @(negedge sck);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge sck);
      if (i == 15) mode = ~mode;
      send(24'($urandom), 24'($urandom));
    end
    repeat (400) @(negedge sck);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
